// File: rtl/priority_demux_dispatch.sv
// Purpose: steer one valid/ready word stream to the lowest-indexed enabled lane; each lane has a one-entry output register.
// Latency: one cycle. A word accepted at edge k is visible on its lane after edge k.
// Backpressure: o_ready is low when no lane is enabled, or when the target lane is full and its consumer is not ready.
module priority_demux_dispatch #(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16,
  localparam int SEL_W  = $clog2(LANES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES-1:0]       i_ctrl,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [LANES-1:0]       o_valid,
  input  logic [LANES-1:0]       i_ready,
  output logic [SEL_W-1:0]       o_sel,
  output logic [COUNT_W-1:0]     o_count
);

  logic             has_target;
  logic [SEL_W-1:0] target;
  logic             accept;

  // Find the lowest set bit of i_ctrl. Scanning downward lets the last hit win.
  always_comb begin
    has_target = 1'b0;
    target     = '0;
    for (int n = LANES - 1; n >= 0; n--) begin
      if (i_ctrl[n]) begin
        has_target = 1'b1;
        target     = SEL_W'(n);
      end
    end
  end

  // A lane can take a word if it is empty, or if its current word drains on this edge.
  // This path depends only on i_ctrl, o_valid and i_ready, never on i_valid or i_data.
  always_comb begin
    o_ready = has_target && (!o_valid[target] || i_ready[target]);
    accept  = i_valid && o_ready;
  end

  // Per-lane output registers. A load on a lane takes precedence over its drain,
  // so a simultaneous drain and load keeps the lane valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_valid <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (accept && (target == SEL_W'(n))) begin
          o_data[n*WIDTH +: WIDTH] <= i_data;
          o_valid[n]               <= 1'b1;
        end else if (o_valid[n] && i_ready[n]) begin
          o_valid[n] <= 1'b0;
        end
      end
    end
  end

  // Record the lane that took the last word, and count accepts saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sel   <= '0;
      o_count <= '0;
    end else if (accept) begin
      o_sel <= target;
      if (o_count != {COUNT_W{1'b1}}) begin
        o_count <= o_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_priority_demux_dispatch.sv
// Bench for priority_demux_dispatch: directed steps followed by a random phase.
// Two instances share all inputs. The second one uses a 4-bit counter so saturation can be observed.
// A per-lane queue scoreboard predicts readiness, delivery, hold behaviour, o_sel and o_count.
module tb_priority_demux_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic [3:0]  ctrl;
  logic [3:0]  rdy;

  logic        ready_a, ready_b;
  logic [31:0] odata_a, odata_b;
  logic [3:0]  ovalid_a, ovalid_b;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per lane holding the undelivered words,
  // plus the last word loaded into each lane, the last target and the accept count.
  logic [7:0] lq[4][$];
  logic [7:0] last_d[4];
  int         exp_sel;
  int         accepts;
  bit         last_acc;

  priority_demux_dispatch #(.LANES(4), .WIDTH(8), .COUNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready_a),
    .i_ctrl(ctrl), .o_data(odata_a), .o_valid(ovalid_a), .i_ready(rdy),
    .o_sel(sel_a), .o_count(cnt_a)
  );

  priority_demux_dispatch #(.LANES(4), .WIDTH(8), .COUNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready_b),
    .i_ctrl(ctrl), .o_data(odata_b), .o_valid(ovalid_b), .i_ready(rdy),
    .o_sel(sel_b), .o_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int target_of(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 4; n++) begin
      lq[n].delete();
      last_d[n] = 8'h00;
    end
    exp_sel  = 0;
    accepts  = 0;
    last_acc = 1'b0;
  endtask

  // Compare every registered output of both instances with the model.
  task automatic check_state();
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int n = 0; n < 4; n++) begin
      ev[n]         = (lq[n].size() != 0);
      ed[n*8 +: 8]  = last_d[n];
    end
    chk("valid_a", ovalid_a, ev);
    chk("valid_b", ovalid_b, ev);
    chk("data_a", odata_a, ed);
    chk("data_b", odata_b, ed);
    chk("sel_a", sel_a, exp_sel);
    chk("sel_b", sel_b, exp_sel);
    chk("count_a", cnt_a, (accepts > 65535) ? 65535 : accepts);
    chk("count_b", cnt_b, (accepts > 15) ? 15 : accepts);
  endtask

  // One clock cycle. Inputs must already be stable.
  // Readiness and deliveries are checked at the falling edge.
  // State is checked 1 time unit after the rising edge.
  task automatic cycle();
    int t;
    bit rdy_exp;
    bit acc;
    bit drn[4];
    @(negedge clk);
    t = target_of(ctrl);
    rdy_exp = (t >= 0) && ((lq[t].size() == 0) || rdy[t]);
    chk("ready_a", ready_a, rdy_exp);
    chk("ready_b", ready_b, rdy_exp);
    acc = valid && rdy_exp;
    for (int n = 0; n < 4; n++) begin
      drn[n] = (lq[n].size() != 0) && rdy[n];
      if (drn[n]) chk("deliver", odata_a[n*8 +: 8], lq[n][0]);
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) if (drn[n]) void'(lq[n].pop_front());
    if (acc) begin
      lq[t].push_back(data);
      last_d[t] = data;
      exp_sel   = t;
      accepts++;
    end
    last_acc = acc;
    check_state();
  endtask

  // Reset raised between clock edges. Outputs must clear before any edge arrives.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    check_state();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; valid = 1'b0; ctrl = 4'b0000; rdy = 4'b0000;
    model_clear();
    #1;
    check_state();
    #11;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: load two lanes, then reset asynchronously while they are valid.
    valid = 1'b1; ctrl = 4'b0001; data = 8'hC1; cycle();
    ctrl = 4'b0010; data = 8'hC2; cycle();
    valid = 1'b0;
    do_reset();
    cycle();

    // Test 2: stream three words to lane 1.
    ctrl = 4'b0110; rdy = 4'b1111; valid = 1'b1;
    data = 8'h11; cycle();
    data = 8'h22; cycle();
    data = 8'h33; cycle();
    valid = 1'b0;
    chk("t2_sel", sel_a, 1);
    chk("t2_count", cnt_a, 3);
    chk("t2_lane1", odata_a[15:8], 8'h33);
    cycle();

    // Test 3: lane 3 is stalled. The held word loads on the same edge that the old word drains.
    ctrl = 4'b1000; rdy = 4'b0111; valid = 1'b1;
    data = 8'hA5; cycle();
    data = 8'h5A; cycle();
    chk("t3_ready", ready_a, 1'b0);
    chk("t3_hold", odata_a[31:24], 8'hA5);
    rdy = 4'b1111; cycle();
    valid = 1'b0;
    chk("t3_load", odata_a[31:24], 8'h5A);
    chk("t3_valid", ovalid_a[3], 1'b1);
    cycle();

    // Test 4: no lane is enabled, so nothing is accepted. Enabling lane 0 accepts the word.
    begin
      int c0;
      c0 = accepts;
      ctrl = 4'b0000; valid = 1'b1; data = 8'h44;
      for (int i = 0; i < 5; i++) cycle();
      chk("t4_count", cnt_a, c0);
      ctrl = 4'b0001; cycle();
      valid = 1'b0;
      chk("t4_accept", cnt_a, c0 + 1);
    end
    cycle();

    // Test 5: change the steering while lane 0 is stalled.
    rdy = 4'b1110; ctrl = 4'b0001; valid = 1'b1; data = 8'h77; cycle();
    ctrl = 4'b0100; data = 8'h88; cycle();
    valid = 1'b0;
    chk("t5_sel", sel_a, 2);
    chk("t5_lane0", odata_a[7:0], 8'h77);
    chk("t5_lane0_vld", ovalid_a[0], 1'b1);
    chk("t5_lane2", odata_a[23:16], 8'h88);
    rdy = 4'b1111; cycle();

    // Random phase. A word that was not accepted stays stable until it is accepted.
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(valid && !last_acc)) begin
        valid = ($urandom_range(0, 3) != 0);
        data  = 8'($urandom);
      end
      ctrl = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      rdy  = 4'($urandom);
      cycle();
    end

    // Drain everything. The scoreboard checks that every word is delivered once.
    valid = 1'b0; rdy = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    chk("drained", ovalid_a, 4'b0000);

    // Test 6: the 4-bit counter has seen well over 20 accepts and stays at 15.
    chk("t6_sat", cnt_b, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
